// File: rtl/ycbcr422_stream_to_rgb.sv
// YCbCr 4:2:2 pixel stream to RGB888 converter.
// Three-stage pipeline (multiply, sum, round/clamp) under one global stall enable.
module ycbcr422_stream_to_rgb #(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 466,
    parameter int unsigned FRAC_BITS  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cfg_mode,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_y,
    input  logic [7:0] s_u,
    input  logic [7:0] s_v,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_r,
    output logic [7:0] m_g,
    output logic [7:0] m_b,
    output logic [9:0] m_x,
    output logic [9:0] m_y,
    output logic       m_sof,
    output logic       m_eol
);

    localparam int unsigned ACC_W = 20;
    localparam int unsigned CRD_W = 10;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned K_W   = 11;

    localparam logic [CRD_W-1:0] X_LAST = CRD_W'(IMG_WIDTH - 1);
    localparam logic [CRD_W-1:0] Y_LAST = CRD_W'(IMG_HEIGHT - 1);

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1 << (FRAC_BITS - 1));
    localparam logic signed [ACC_W-1:0] C_OFF   = ACC_W'(128);
    localparam logic signed [ACC_W-1:0] C_BLACK = ACC_W'(16);
    localparam logic signed [ACC_W-1:0] C_LIM   = ACC_W'(298);
    localparam logic signed [ACC_W-1:0] C_FULL  = ACC_W'(256);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);

    logic en;
    logic accept;

    logic [CRD_W-1:0] x_q;
    logic [CRD_W-1:0] y_q;
    logic [1:0]       mode_q;
    logic [PIX_W-1:0] u_q;
    logic [PIX_W-1:0] v_q;

    logic             first_px;
    logic [1:0]       mode_eff;
    logic [PIX_W-1:0] u_eff;
    logic [PIX_W-1:0] v_eff;
    logic [K_W-1:0]   k_r;
    logic [K_W-1:0]   k_gb;
    logic [K_W-1:0]   k_gr;
    logic [K_W-1:0]   k_b;

    logic signed [ACC_W-1:0] y_w;
    logic signed [ACC_W-1:0] cb_w;
    logic signed [ACC_W-1:0] cr_w;
    logic signed [ACC_W-1:0] y_term;
    logic signed [ACC_W-1:0] p_r;
    logic signed [ACC_W-1:0] p_gb;
    logic signed [ACC_W-1:0] p_gr;
    logic signed [ACC_W-1:0] p_b;

    // stage 1: products
    logic                    s1_valid;
    logic signed [ACC_W-1:0] s1_y;
    logic signed [ACC_W-1:0] s1_pr;
    logic signed [ACC_W-1:0] s1_pgb;
    logic signed [ACC_W-1:0] s1_pgr;
    logic signed [ACC_W-1:0] s1_pb;
    logic [CRD_W-1:0]        s1_x;
    logic [CRD_W-1:0]        s1_yc;
    logic                    s1_sof;
    logic                    s1_eol;

    // stage 2: sums
    logic                    s2_valid;
    logic signed [ACC_W-1:0] s2_r;
    logic signed [ACC_W-1:0] s2_g;
    logic signed [ACC_W-1:0] s2_b;
    logic [CRD_W-1:0]        s2_x;
    logic [CRD_W-1:0]        s2_yc;
    logic                    s2_sof;
    logic                    s2_eol;

    function automatic logic [PIX_W-1:0] round_clamp(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] t;
        t = (v + RND) >>> FRAC_BITS;
        if (t < 0) begin
            return '0;
        end else if (t > PIX_MAX) begin
            return '1;
        end
        return t[PIX_W-1:0];
    endfunction

    assign en      = !m_valid || m_ready;
    assign s_ready = en;
    assign accept  = s_valid && en;

    // Effective mode/chroma for the pixel at the input: (0,0) sees the new mode,
    // odd pixels reuse the chroma pair captured on their even neighbour.
    always_comb begin
        first_px = (x_q == '0) && (y_q == '0);
        mode_eff = first_px ? cfg_mode : mode_q;
        u_eff    = x_q[0] ? u_q : s_u;
        v_eff    = x_q[0] ? v_q : s_v;

        k_r  = '0;
        k_gb = '0;
        k_gr = '0;
        k_b  = '0;
        case (mode_eff)
            2'd0: begin k_r = K_W'(359); k_gb = K_W'(88);  k_gr = K_W'(183); k_b = K_W'(454); end
            2'd1: begin k_r = K_W'(409); k_gb = K_W'(100); k_gr = K_W'(208); k_b = K_W'(516); end
            2'd2: begin k_r = K_W'(403); k_gb = K_W'(48);  k_gr = K_W'(120); k_b = K_W'(475); end
            default: ;
        endcase

        y_w    = ACC_W'(s_y);
        cb_w   = ACC_W'(u_eff) - C_OFF;
        cr_w   = ACC_W'(v_eff) - C_OFF;
        y_term = (mode_eff == 2'd1) ? (y_w - C_BLACK) * C_LIM : y_w * C_FULL;
        p_r    = cr_w * ACC_W'(k_r);
        p_gb   = cb_w * ACC_W'(k_gb);
        p_gr   = cr_w * ACC_W'(k_gr);
        p_b    = cb_w * ACC_W'(k_b);
    end

    // Raster position, captured chroma and per-frame mode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= '0;
            u_q    <= '0;
            v_q    <= '0;
        end else if (accept) begin
            if (!x_q[0]) begin
                u_q <= s_u;
                v_q <= s_v;
            end
            if (first_px) begin
                mode_q <= cfg_mode;
            end
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + CRD_W'(1);
            end else begin
                x_q <= x_q + CRD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_y     <= '0;
            s1_pr    <= '0;
            s1_pgb   <= '0;
            s1_pgr   <= '0;
            s1_pb    <= '0;
            s1_x     <= '0;
            s1_yc    <= '0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s2_valid <= 1'b0;
            s2_r     <= '0;
            s2_g     <= '0;
            s2_b     <= '0;
            s2_x     <= '0;
            s2_yc    <= '0;
            s2_sof   <= 1'b0;
            s2_eol   <= 1'b0;
            m_valid  <= 1'b0;
            m_r      <= '0;
            m_g      <= '0;
            m_b      <= '0;
            m_x      <= '0;
            m_y      <= '0;
            m_sof    <= 1'b0;
            m_eol    <= 1'b0;
        end else if (en) begin
            s1_valid <= accept;
            s1_y     <= y_term;
            s1_pr    <= p_r;
            s1_pgb   <= p_gb;
            s1_pgr   <= p_gr;
            s1_pb    <= p_b;
            s1_x     <= x_q;
            s1_yc    <= y_q;
            s1_sof   <= accept && first_px;
            s1_eol   <= accept && (x_q == X_LAST);

            s2_valid <= s1_valid;
            s2_r     <= s1_y + s1_pr;
            s2_g     <= s1_y - s1_pgb - s1_pgr;
            s2_b     <= s1_y + s1_pb;
            s2_x     <= s1_x;
            s2_yc    <= s1_yc;
            s2_sof   <= s1_sof;
            s2_eol   <= s1_eol;

            m_valid  <= s2_valid;
            m_r      <= round_clamp(s2_r);
            m_g      <= round_clamp(s2_g);
            m_b      <= round_clamp(s2_b);
            m_x      <= s2_x;
            m_y      <= s2_yc;
            m_sof    <= s2_sof;
            m_eol    <= s2_eol;
        end
    end

endmodule

// File: tb/tb_ycbcr422_stream_to_rgb.sv
// Scoreboard bench for ycbcr422_stream_to_rgb: a reference model queues the expected
// pixel on every accepted input and a negedge monitor compares each delivered output.
module tb_ycbcr422_stream_to_rgb;

    localparam int unsigned W = 4;
    localparam int unsigned H = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [9:0] x;
        logic [9:0] y;
        logic       sof;
        logic       eol;
    } px_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] cfg_mode;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_y;
    logic [7:0] s_u;
    logic [7:0] s_v;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_r;
    logic [7:0] m_g;
    logic [7:0] m_b;
    logic [9:0] m_x;
    logic [9:0] m_y;
    logic       m_sof;
    logic       m_eol;

    px_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  out_cnt = 0;
    int  eol_cnt = 0;
    int  acc_cnt = 0;

    int mx, my, mmode, mu, mv;

    logic hold_v = 1'b0;
    px_t  hold_val;
    px_t  got;
    px_t  exp_px;

    always #5 clk = ~clk;

    ycbcr422_stream_to_rgb #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .FRAC_BITS (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_mode(cfg_mode),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_y     (s_y),
        .s_u     (s_u),
        .s_v     (s_v),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_r     (m_r),
        .m_g     (m_g),
        .m_b     (m_b),
        .m_x     (m_x),
        .m_y     (m_y),
        .m_sof   (m_sof),
        .m_eol   (m_eol)
    );

    function automatic int clamp8(input int v);
        int t;
        t = (v + 128) >>> 8;
        if (t < 0) return 0;
        if (t > 255) return 255;
        return t;
    endfunction

    function automatic px_t ref_px(input int yy, input int uu, input int vv,
                                   input int md, input int px, input int py);
        px_t e;
        int  yp, cb, cr, kr, kgb, kgr, kb, r, g, b;
        cb = uu - 128;
        cr = vv - 128;
        kr = 0; kgb = 0; kgr = 0; kb = 0;
        case (md)
            0: begin kr = 359; kgb = 88;  kgr = 183; kb = 454; end
            1: begin kr = 409; kgb = 100; kgr = 208; kb = 516; end
            2: begin kr = 403; kgb = 48;  kgr = 120; kb = 475; end
            default: ;
        endcase
        if (md == 3) begin
            r = yy; g = yy; b = yy;
        end else begin
            yp = (md == 1) ? (yy - 16) * 298 : yy * 256;
            r  = clamp8(yp + kr * cr);
            g  = clamp8(yp - kgb * cb - kgr * cr);
            b  = clamp8(yp + kb * cb);
        end
        e.r   = 8'(r);
        e.g   = 8'(g);
        e.b   = 8'(b);
        e.x   = 10'(px);
        e.y   = 10'(py);
        e.sof = (px == 0) && (py == 0);
        e.eol = (px == int'(W) - 1);
        return e;
    endfunction

    task automatic model_reset();
        sb.delete();
        mx = 0; my = 0; mmode = 0; mu = 0; mv = 0;
    endtask

    task automatic accept_model(input int yy, input int uu, input int vv);
        if (mx == 0 && my == 0) mmode = int'(cfg_mode);
        if (mx % 2 == 0) begin
            mu = uu;
            mv = vv;
        end
        sb.push_back(ref_px(yy, mu, mv, mmode, mx, my));
        acc_cnt++;
        if (mx == int'(W) - 1) begin
            mx = 0;
            my = (my == int'(H) - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    // One clock: drive at posedge+1, decide acceptance before the edge, return at next posedge+1.
    task automatic step(input logic vld, input logic [7:0] yy, input logic [7:0] uu,
                        input logic [7:0] vv, input logic rdy);
        s_valid = vld;
        s_y     = yy;
        s_u     = uu;
        s_v     = vv;
        m_ready = rdy;
        #1;
        if (s_valid && s_ready && rst_n) accept_model(int'(yy), int'(uu), int'(vv));
        @(posedge clk);
        #1;
    endtask

    task automatic step_rand(input logic rdy);
        step(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), rdy);
    endtask

    task automatic to_frame_start();
        int guard = 0;
        while (!(mx == 0 && my == 0) && guard < 100) begin
            step_rand(1'b1);
            guard++;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
            guard++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d pixels never delivered, required 0", sb.size());
        end
    endtask

    // Output monitor: scoreboard compare on every transfer, hold check while stalled.
    always @(negedge clk) begin
        got = '{r: m_r, g: m_g, b: m_b, x: m_x, y: m_y, sof: m_sof, eol: m_eol};
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                n_cmp++;
                if (got !== hold_val || m_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL hold: got %h valid=%b, required %h valid=1", got, m_valid, hold_val);
                end
            end
            if (m_valid && m_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_output: got pixel %h, required no output", got);
                end else begin
                    exp_px = sb.pop_front();
                    out_cnt++;
                    if (m_eol) eol_cnt++;
                    if (got !== exp_px) begin
                        n_err++;
                        $display("FAIL pixel: got rgb=%0d,%0d,%0d xy=%0d,%0d sof=%b eol=%b, required rgb=%0d,%0d,%0d xy=%0d,%0d sof=%b eol=%b",
                                 got.r, got.g, got.b, got.x, got.y, got.sof, got.eol,
                                 exp_px.r, exp_px.g, exp_px.b, exp_px.x, exp_px.y, exp_px.sof, exp_px.eol);
                    end
                end
            end
            hold_v   = m_valid && !m_ready;
            hold_val = got;
        end
    end

    task automatic test_reset();
        #2;
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_handshake: m_valid=%b s_ready=%b, required 0 1", m_valid, s_ready);
        end
        n_cmp++;
        if ({m_r, m_g, m_b, m_x, m_y, m_sof, m_eol} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, required 0", {m_r, m_g, m_b, m_x, m_y, m_sof, m_eol});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    endtask

    task automatic test_basic();
        cfg_mode = 2'd0;
        step(1'b1, 8'd128, 8'd128, 8'd128, 1'b1);
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        n_cmp++;
        if (m_valid !== 1'b1 || m_r !== 8'd128 || m_g !== 8'd128 || m_b !== 8'd128) begin
            n_err++;
            $display("FAIL basic_latency_rgb: valid=%b rgb=%0d,%0d,%0d, required 1 128,128,128", m_valid, m_r, m_g, m_b);
        end
        n_cmp++;
        if (m_sof !== 1'b1 || m_x !== 10'd0 || m_y !== 10'd0) begin
            n_err++;
            $display("FAIL basic_coords: sof=%b x=%0d y=%0d, required 1 0 0", m_sof, m_x, m_y);
        end
    endtask

    task automatic test_limited();
        to_frame_start();
        cfg_mode = 2'd1;
        step(1'b1, 8'd235, 8'd128, 8'd128, 1'b1);
        cfg_mode = 2'd0;
        step(1'b1, 8'd16, 8'd7, 8'd9, 1'b1);
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        n_cmp++;
        if (m_valid !== 1'b1 || {m_r, m_g, m_b} !== {8'd255, 8'd255, 8'd255}) begin
            n_err++;
            $display("FAIL limited_white: valid=%b rgb=%0d,%0d,%0d, required 1 255,255,255", m_valid, m_r, m_g, m_b);
        end
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        n_cmp++;
        if (m_valid !== 1'b1 || {m_r, m_g, m_b} !== 24'd0) begin
            n_err++;
            $display("FAIL limited_black: valid=%b rgb=%0d,%0d,%0d, required 1 0,0,0", m_valid, m_r, m_g, m_b);
        end
        to_frame_start();
    endtask

    task automatic test_clamp();
        cfg_mode = 2'd0;
        step(1'b1, 8'd255, 8'd255, 8'd255, 1'b1);
        step(1'b1, 8'd50, 8'd1, 8'd1, 1'b1);
        step(1'b1, 8'd0, 8'd0, 8'd0, 1'b1);
        n_cmp++;
        if (m_r !== 8'd255 || m_g !== 8'd121 || m_b !== 8'd255) begin
            n_err++;
            $display("FAIL clamp_high: rgb=%0d,%0d,%0d, required 255,121,255", m_r, m_g, m_b);
        end
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        n_cmp++;
        if (m_r !== 8'd0 || m_g !== 8'd136 || m_b !== 8'd0) begin
            n_err++;
            $display("FAIL clamp_low: rgb=%0d,%0d,%0d, required 0,136,0", m_r, m_g, m_b);
        end
    endtask

    task automatic test_chroma();
        while (mx % 2 != 0) step_rand(1'b1);
        step(1'b1, 8'd100, 8'd200, 8'd50, 1'b1);
        step(1'b1, 8'd100, 8'd0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        n_cmp++;
        if ({m_r, m_g, m_b} !== {8'd0, 8'd131, 8'd228}) begin
            n_err++;
            $display("FAIL chroma_even: rgb=%0d,%0d,%0d, required 0,131,228", m_r, m_g, m_b);
        end
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        n_cmp++;
        if ({m_r, m_g, m_b} !== {8'd0, 8'd131, 8'd228}) begin
            n_err++;
            $display("FAIL chroma_odd: rgb=%0d,%0d,%0d, required 0,131,228", m_r, m_g, m_b);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 30; i++) begin
            if (i >= 8 && i < 13) begin
                s_valid = 1'b1;
                m_ready = 1'b0;
                #1;
                n_cmp++;
                if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_ready: m_valid=%b s_ready=%b, required 1 0", m_valid, s_ready);
                end
                step_rand(1'b0);
            end else begin
                step_rand(1'b1);
            end
        end
        drain();
    endtask

    task automatic test_frame_count();
        int out0, eol0, acc0, guard;
        cfg_mode = 2'd3;
        to_frame_start();
        drain();
        out0  = out_cnt;
        eol0  = eol_cnt;
        acc0  = acc_cnt;
        guard = 0;
        while (acc_cnt - acc0 < int'(2 * W * H) && guard < 500) begin
            if (acc_cnt - acc0 == int'(W * H) - 3) cfg_mode = 2'($urandom_range(0, 2));
            step_rand(1'($urandom_range(0, 3) != 0));
            guard++;
        end
        drain();
        n_cmp++;
        if (out_cnt - out0 != int'(2 * W * H)) begin
            n_err++;
            $display("FAIL frame_count: got %0d outputs, required %0d", out_cnt - out0, 2 * W * H);
        end
        n_cmp++;
        if (eol_cnt - eol0 != int'(2 * H)) begin
            n_err++;
            $display("FAIL eol_count: got %0d, required %0d", eol_cnt - eol0, 2 * H);
        end
    endtask

    task automatic test_back_to_back();
        int out0;
        cfg_mode = 2'd2;
        out0 = out_cnt;
        for (int i = 0; i < 20; i++) step_rand(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        n_cmp++;
        if (out_cnt - out0 != 20) begin
            n_err++;
            $display("FAIL back_to_back: got %0d outputs in 23 clocks, required 20", out_cnt - out0);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        while (mx == 0) step_rand(1'b1);
        for (int i = 0; i < 3; i++) step_rand(1'b1);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_sof !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_clear: m_valid=%b s_ready=%b sof=%b, required 0 1 0", m_valid, s_ready, m_sof);
        end
        model_reset();
        s_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cfg_mode = 2'd2;
        step(1'b1, 8'd128, 8'd128, 8'd128, 1'b1);
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        n_cmp++;
        if (m_valid !== 1'b1 || m_sof !== 1'b1 || m_x !== 10'd0 || m_y !== 10'd0 || m_r !== 8'd128) begin
            n_err++;
            $display("FAIL reset_mid_restart: valid=%b sof=%b x=%0d y=%0d r=%0d, required 1 1 0 0 128",
                     m_valid, m_sof, m_x, m_y, m_r);
        end
        drain();
    endtask

    initial begin
        rst_n    = 1'b0;
        cfg_mode = 2'd0;
        s_valid  = 1'b0;
        s_y      = '0;
        s_u      = '0;
        s_v      = '0;
        m_ready  = 1'b1;
        model_reset();
        test_reset();
        test_basic();
        test_limited();
        test_clamp();
        test_chroma();
        test_stall();
        test_frame_count();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
